// File: rtl/miriscv_ctrl_pkg.sv
// Shared types for the miriscv pipeline control unit: FSM states and counter selects.
package miriscv_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN,
        HALTED
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CNT_CYCLE,
        CNT_RET,
        CNT_MISP,
        CNT_STALL
    } cnt_sel_e;

    localparam int CNT_NUM = 4;

endpackage

// File: rtl/miriscv_perf_cnt.sv
// Wrapping performance counter; clear has priority over increment.
module miriscv_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] value_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            value_o <= '0;
        end else if (inc_i) begin
            value_o <= value_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/miriscv_pipe_ctrl.sv
// Pipeline control: stall/kill generation, fetch redirection, halt/drain FSM, perf counters.
// state  | meaning
// BOOT   | boot PC forced for BOOT_CYCLES cycles after reset release
// RUN    | normal operation
// DRAIN  | halt requested, stage 0 held while older stages empty
// HALTED | pipeline empty and held until halt request drops
module miriscv_pipe_ctrl
    import miriscv_ctrl_pkg::*;
#(
    parameter int                  XLEN           = 32,
    parameter int                  GPR_ADDR_W     = 5,
    parameter int                  NSTAGES        = 5,
    parameter logic [NSTAGES-1:1]  INTERLOCK_MASK = '1,
    parameter int                  BOOT_CYCLES    = 2,
    parameter int                  CNT_W          = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [XLEN-1:0]                   boot_addr_i,
    input  logic [NSTAGES-1:0]                stall_req_i,
    input  logic [NSTAGES-1:0]                valid_i,
    input  logic [2*GPR_ADDR_W-1:0]           rs_addr_i,
    input  logic [1:0]                        rs_req_i,
    input  logic [(NSTAGES-1)*GPR_ADDR_W-1:0] rd_addr_i,
    input  logic [NSTAGES-1:1]                rd_we_i,
    input  logic                              res_prediction_i,
    input  logic                              res_taken_i,
    input  logic [XLEN-1:0]                   res_target_pc_i,
    input  logic [XLEN-1:0]                   res_next_pc_i,
    input  logic                              redirect_req_i,
    input  logic [XLEN-1:0]                   redirect_pc_i,
    input  logic                              halt_req_i,
    input  logic [1:0]                        cnt_sel_i,
    input  logic                              cnt_clr_i,
    output logic [NSTAGES-1:0]                stall_o,
    output logic [NSTAGES-1:0]                kill_o,
    output logic                              force_f_o,
    output logic [XLEN-1:0]                   force_pc_o,
    output logic                              halted_o,
    output logic [CNT_W-1:0]                  cnt_rdata_o
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);

    ctrl_state_e                          state_q, state_d;
    logic [BW-1:0]                        boot_cnt_q, boot_cnt_d;
    logic                                 boot_w, misp, redir, any_haz;
    logic [NSTAGES-1:1]                   haz;
    logic [NSTAGES-1:1][GPR_ADDR_W-1:0]   rd_addr;
    logic [GPR_ADDR_W-1:0]                rs1, rs2;
    logic [CNT_NUM-1:0]                   cnt_inc;
    logic [CNT_W-1:0]                     cnt_val [CNT_NUM];
    cnt_sel_e                             cnt_sel;
    logic                                 halted_q;
    logic [CNT_W-1:0]                     cnt_rdata_q;

    assign rd_addr = rd_addr_i;
    assign rs1     = rs_addr_i[GPR_ADDR_W-1:0];
    assign rs2     = rs_addr_i[2*GPR_ADDR_W-1:GPR_ADDR_W];

    always_comb begin
        haz = '0;
        for (int k = 1; k < NSTAGES; k++) begin
            haz[k] = valid_i[0] & valid_i[k] & rd_we_i[k] & INTERLOCK_MASK[k]
                   & (rd_addr[k] != '0)
                   & ((rs_req_i[0] & (rs1 == rd_addr[k])) | (rs_req_i[1] & (rs2 == rd_addr[k])));
        end
    end

    assign any_haz = |haz;

    // Reset is treated as part of boot so the fetch PC is pinned before the first edge.
    assign boot_w = rst_i | (state_q == BOOT);
    assign misp   = ~boot_w & valid_i[NSTAGES-1] & (res_prediction_i ^ res_taken_i);
    assign redir  = ~boot_w & redirect_req_i;

    always_comb begin
        stall_o = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            stall_o[k] = |(stall_req_i >> k);
        end
        stall_o[0] = stall_o[0] | any_haz
                   | (~rst_i & ((state_q == DRAIN) | (state_q == HALTED)));
    end

    assign kill_o    = {NSTAGES{misp | redir}};
    assign force_f_o = boot_w | redir | misp;

    always_comb begin
        force_pc_o = '0;
        if (boot_w) begin
            force_pc_o = boot_addr_i;
        end else if (redir) begin
            force_pc_o = redirect_pc_i;
        end else if (misp) begin
            force_pc_o = res_taken_i ? res_target_pc_i : res_next_pc_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - BW'(1);
                end
            end
            RUN: begin
                if (halt_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt_req_i) begin
                    state_d = RUN;
                end else if (valid_i[NSTAGES-1:1] == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req_i) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        cnt_inc            = '0;
        cnt_inc[CNT_CYCLE] = 1'b1;
        cnt_inc[CNT_RET]   = valid_i[NSTAGES-1] & ~stall_o[NSTAGES-1] & ~kill_o[NSTAGES-1];
        cnt_inc[CNT_MISP]  = misp;
        cnt_inc[CNT_STALL] = stall_o[0];
    end

    for (genvar i = 0; i < CNT_NUM; i++) begin : g_cnt
        miriscv_perf_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (cnt_clr_i),
            .inc_i   (cnt_inc[i]),
            .value_o (cnt_val[i])
        );
    end

    assign cnt_sel = cnt_sel_e'(cnt_sel_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            boot_cnt_q  <= BOOT_INIT;
            halted_q    <= 1'b0;
            cnt_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            halted_q    <= (state_d == HALTED);
            cnt_rdata_q <= cnt_val[cnt_sel];
        end
    end

    assign halted_o    = halted_q;
    assign cnt_rdata_o = cnt_rdata_q;

endmodule
